mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequential arbiter that shares a single `mem_system` port between the fetch stage (instruction reads) and the memory stage (data reads/writes) for the unified-memory configuration of the pipeline. It grants one requester at a time and latches that requester's address and write data for the whole transaction. It forwards the `Done` completion back to the granted requester and produces per-requester stall signals. Data accesses have priority, bounded by a starvation limit so fetch always makes progress.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while fetch waits. Range 1–7.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_rd` in 1: fetch read request, held until `if_done`.
- `if_addr` in 16: fetch address.
- `if_rdata` out 16: fetch read data, registered, held until the next fetch completion.
- `if_done` out 1: one-cycle fetch completion pulse.
- `if_stall` out 1: fetch waiting, `if_rd & ~if_done`.
- `dm_rd` in 1: data read request, held until `dm_done`.
- `dm_wr` in 1: data write request, held until `dm_done`.
- `dm_addr` in 16: data address.
- `dm_wdata` in 16: data write value.
- `dm_rdata` out 16: data read data, registered, held until the next data-read completion.
- `dm_done` out 1: one-cycle data completion pulse.
- `dm_stall` out 1: data waiting, `(dm_rd|dm_wr) & ~dm_done`.
- `mem_rd` out 1: to `mem_system` `Rd`.
- `mem_wr` out 1: to `mem_system` `Wr`.
- `mem_addr` out 16: to `mem_system` `Addr`.
- `mem_wdata` out 16: to `mem_system` `DataIn`.
- `mem_rdata` in 16: from `mem_system` `DataOut`.
- `mem_done` in 1: from `mem_system` `Done`.
- `err` out 1: protocol error, `dm_rd & dm_wr` simultaneously.

## Operation
- States:
  - IDLE: no transaction.
  - SERVE_IF: fetch read in flight.
  - SERVE_DM: data access in flight.
- Grant decision is made in IDLE, or in a SERVE state in the cycle `mem_done`=1.
  - Data request pending and `starve_cnt < STARVE_LIMIT` → SERVE_DM.
  - Otherwise, fetch pending → SERVE_IF.
  - Otherwise, data pending → SERVE_DM.
  - Otherwise → IDLE.
- On grant, latch the winner's address into `addr_q`. On a data grant, also latch `dm_wdata` into `wdata_q` and latch the op (write if `dm_wr`, else read).
- While in a SERVE state:
  - `mem_addr`=`addr_q` and `mem_wdata`=`wdata_q`.
  - SERVE_IF: `mem_rd`=1.
  - SERVE_DM: `mem_rd`=~op_wr and `mem_wr`=op_wr.
  - All asserted continuously until the cycle `mem_done` is sampled high, inclusive.
- In IDLE, `mem_rd`=`mem_wr`=0, and `mem_addr` and `mem_wdata` hold their last latched values.
- Completion occurs in a SERVE state when `mem_done`=1:
  - The granted requester's `*_done`=1 combinationally.
  - On a read, `mem_rdata` is captured into `*_rdata` at that edge.
  - A data write completion does not change `dm_rdata`.
- `starve_cnt` (3 bits):
  - Increments on each data grant made while `if_rd`=1.
  - Clears on any fetch grant, and whenever `if_rd`=0 in a grant cycle.
  - Saturates at 7.
- `dm_rd` & `dm_wr` both high: `err`=1 while they are asserted together; the access is serviced as a write.
- Changes to the requester's address or data after grant are ignored.

## Timing
- Reset values: state IDLE, `starve_cnt`=0, all outputs and latched registers 0.
- Request first seen in IDLE at cycle N → `mem_rd`/`mem_wr` asserted from cycle N+1.
- Back-to-back: completion at cycle M with another request pending → the next transaction drives memory at M+1, with no IDLE bubble.
- `mem_done` high in the same cycle as a state change is honoured by the state it is sampled in.
- `*_done` is high only while `mem_done`=1 in the matching SERVE state. `mem_done` in IDLE is ignored.
- Minimum request-to-done latency is 2 cycles: the grant edge, then `mem_done` in the first SERVE cycle.
- A requester that drops its request while granted does not abort the transaction; the arbiter completes it and discards the done.
- Reset asserted mid-transaction: all state and outputs return to reset values immediately. `mem_system` shares `rst`, so no transaction survives.

## Test plan
- Reset, then `if_rd`=1, `if_addr`=0x0010, `mem_done` after 3 SERVE cycles with `mem_rdata`=0x1234 → `mem_rd`=1 and `mem_addr`=0x0010 for 3 cycles, then `if_done` pulse and `if_rdata`=0x1234 held.
- `if_rd` and `dm_wr` raised together, `dm_addr`=0x0200, `dm_wdata`=0xBEEF → data served first with `mem_wr`=1 and `mem_wdata`=0xBEEF, then fetch served back-to-back with no IDLE cycle.
- Fetch held and data requests continuously pending, `STARVE_LIMIT`=4 → exactly 4 data grants, then 1 fetch grant, pattern repeating.
- `dm_rd`=`dm_wr`=1 → `err`=1 and `mem_wr`=1. `dm_addr` changed mid-transaction → `mem_addr` unchanged.
- `rst` pulsed while in SERVE_DM → state IDLE and all outputs 0 asynchronously. `mem_done`=1 pulsed in IDLE → no `*_done` asserted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one mem_system port between instruction fetch and the data stage.
// Data has priority, but fetch is guaranteed a grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_rd,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        op_wr_q, op_wr_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;

  logic dm_req;
  logic grant_en;
  logic gnt_dm;
  logic gnt_if;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign dm_req   = dm_rd | dm_wr;
  // A new owner is chosen when idle or as the current transaction completes.
  assign grant_en = (state_q == IDLE) | mem_done;

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    gnt_dm     = 1'b0;
    gnt_if     = 1'b0;

    if (if_done) begin
      if_rdata_d = mem_rdata;
    end
    if (dm_done && !op_wr_q) begin
      dm_rdata_d = mem_rdata;
    end

    if (grant_en) begin
      if (dm_req && (starve_q < LIMIT)) begin
        gnt_dm = 1'b1;
      end else if (if_rd) begin
        gnt_if = 1'b1;
      end else if (dm_req) begin
        gnt_dm = 1'b1;
      end

      if (gnt_dm) begin
        state_d = SERVE_DM;
        addr_d  = dm_addr;
        wdata_d = dm_wdata;
        op_wr_d = dm_wr;
      end else if (gnt_if) begin
        state_d = SERVE_IF;
        addr_d  = if_addr;
      end else begin
        state_d = IDLE;
      end

      if (gnt_if || !if_rd) begin
        starve_d = 3'd0;
      end else if (gnt_dm) begin
        starve_d = sat_inc3(starve_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= 3'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      op_wr_q    <= 1'b0;
      if_rdata_q <= 16'h0000;
      dm_rdata_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_wr_q    <= op_wr_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign if_done   = (state_q == SERVE_IF) & mem_done;
  assign dm_done   = (state_q == SERVE_DM) & mem_done;
  assign if_stall  = if_rd & ~if_done;
  assign dm_stall  = dm_req & ~dm_done;
  assign mem_rd    = (state_q == SERVE_IF) | ((state_q == SERVE_DM) & ~op_wr_q);
  assign mem_wr    = (state_q == SERVE_DM) & op_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = dm_rd & dm_wr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a requester/memory driver, a completion
// monitor popping expected transactions, and a directed stimulus sequence.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_rd, dm_rd, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_rd, mem_wr, err;

  typedef struct {
    logic        is_dm;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // stimulus-owned command variables, read by the driver
  int          lat = 1;
  int          if_go = 0, dm_go = 0, glitch_go = 0, idle_go = 0;
  int          if_n = 0, dm_n = 0;
  logic        dm_rd_v = 1'b0, dm_wr_v = 1'b0;
  logic [15:0] if_a = 16'h0, dm_a = 16'h0, dm_d = 16'h0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_rd(if_rd), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic d, input logic w, input logic [15:0] a,
                              input logic [15:0] wd, input logic [15:0] rd, input int l);
    exp_t e;
    e.is_dm = d; e.wr = w; e.addr = a; e.wdata = wd; e.rdata = rd; e.lat = l;
    return e;
  endfunction

  // Requesters and memory model: memory answers after `lat` serve cycles with addr+0x1224.
  initial begin
    int cyc, if_seen, dm_seen, gl_seen, id_seen, if_left, dm_left;
    if_rd = 0; dm_rd = 0; dm_wr = 0; mem_done = 0; mem_rdata = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    cyc = 0; if_seen = 0; dm_seen = 0; gl_seen = 0; id_seen = 0; if_left = 0; dm_left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if_rd = 0; dm_rd = 0; dm_wr = 0; mem_done = 0; cyc = 0; if_left = 0; dm_left = 0;
      end else begin
        if (mem_done) cyc = 0;
        mem_done = 0;
        if (id_seen != idle_go) begin
          id_seen = idle_go;
          mem_done = 1;
        end else if (mem_rd || mem_wr) begin
          cyc++;
          if (cyc >= lat) begin
            mem_done  = 1;
            mem_rdata = mem_addr + 16'h1224;
          end
        end
        if (gl_seen != glitch_go) begin
          gl_seen  = glitch_go;
          dm_addr  = 16'hFFFF;
          dm_wdata = 16'h0BAD;
        end
        #2;
        if (if_done && if_left > 0) begin
          if_left--;
          if (if_left == 0) if_rd = 0;
        end
        if (dm_done && dm_left > 0) begin
          dm_left--;
          if (dm_left == 0) begin
            dm_rd = 0; dm_wr = 0;
          end else begin
            dm_addr  = dm_addr + 16'h1;
            dm_wdata = dm_wdata + 16'h1;
          end
        end
        if (if_seen != if_go) begin
          if_seen = if_go; if_left = if_n; if_rd = 1; if_addr = if_a;
        end
        if (dm_seen != dm_go) begin
          dm_seen = dm_go; dm_left = dm_n;
          dm_rd = dm_rd_v; dm_wr = dm_wr_v; dm_addr = dm_a; dm_wdata = dm_d;
        end
      end
    end
  end

  // Monitor: every completion pops the oldest expected transaction.
  initial begin
    int scnt;
    logic if_pend, dm_pend;
    logic [15:0] if_exp, dm_exp;
    exp_t e;
    scnt = 0; if_pend = 0; dm_pend = 0; if_exp = 0; dm_exp = 0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin
        scnt = 0; if_pend = 0; dm_pend = 0;
      end else begin
        if (if_pend) begin chk("if_rdata_capture", 32'(if_rdata), 32'(if_exp)); if_pend = 0; end
        if (dm_pend) begin chk("dm_rdata_capture", 32'(dm_rdata), 32'(dm_exp)); dm_pend = 0; end
        if (mem_rd || mem_wr) scnt++;
        if (if_done || dm_done) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done if_done=%0b dm_done=%0b required none", if_done, dm_done);
          end else begin
            e = sb.pop_front();
            chk("done_owner_dm", 32'(dm_done), 32'(e.is_dm));
            chk("done_owner_if", 32'(if_done), 32'(!e.is_dm));
            chk("mem_wr", 32'(mem_wr), 32'(e.wr));
            chk("mem_rd", 32'(mem_rd), 32'(!e.wr));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("serve_cycles", 32'(scnt), 32'(e.lat));
            if (e.wr) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
            else if (e.is_dm) begin dm_pend = 1; dm_exp = e.rdata; end
            else begin if_pend = 1; if_exp = e.rdata; end
          end
          scnt = 0;
        end
      end
    end
  end

  task automatic wait_serve(input string nm);
    logic found;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #4;
      if (mem_rd || mem_wr) found = 1;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    logic found;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk); #4;
      if (sb.size() == 0 && !mem_rd && !mem_wr && !if_rd && !dm_rd && !dm_wr) found = 1;
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  initial begin
    logic found;
    rst = 1;
    repeat (3) @(negedge clk);
    #1 rst = 0;
    @(negedge clk); #4;
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    chk("rst_flags", 32'({if_done, dm_done, if_stall, dm_stall, err}), 32'd0);

    // single fetch, three serve cycles
    lat = 3;
    sb.push_back(mk(0, 0, 16'h0010, 16'h0000, 16'h1234, 3));
    if_n = 1; if_a = 16'h0010; if_go++;
    wait_serve("t1_serve_start");
    chk("t1_mem_rd", 32'(mem_rd), 32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("t1_if_stall", 32'(if_stall), 32'd1);
    wait_idle("t1_idle");
    repeat (3) @(negedge clk); #4;
    chk("t1_if_rdata_held", 32'(if_rdata), 32'h1234);
    chk("t1_if_stall_off", 32'(if_stall), 32'd0);

    // simultaneous fetch and data write: data first, fetch back-to-back
    lat = 1;
    sb.push_back(mk(1, 1, 16'h0200, 16'hBEEF, 16'h0000, 1));
    sb.push_back(mk(0, 0, 16'h0020, 16'h0000, 16'h1244, 1));
    dm_n = 1; dm_rd_v = 0; dm_wr_v = 1; dm_a = 16'h0200; dm_d = 16'hBEEF;
    if_n = 1; if_a = 16'h0020;
    if_go++; dm_go++;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #4;
      if (dm_done) found = 1;
    end
    chk("t2_dm_done_seen", 32'(found), 32'd1);
    chk("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    @(negedge clk); #4;
    chk("t2_b2b_mem_rd", 32'(mem_rd), 32'd1);
    chk("t2_b2b_mem_addr", 32'(mem_addr), 32'h0020);
    wait_idle("t2_idle");

    // starvation: 4 data reads, 1 fetch, repeated
    lat = 1;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin
        sb.push_back(mk(1, 0, 16'(16'h0400 + 4 * k + j), 16'h0000,
                        16'(16'h1624 + 4 * k + j), 1));
      end
      sb.push_back(mk(0, 0, 16'h0100, 16'h0000, 16'h1324, 1));
    end
    dm_n = 8; dm_rd_v = 1; dm_wr_v = 0; dm_a = 16'h0400; dm_d = 16'h0000;
    if_n = 2; if_a = 16'h0100;
    if_go++; dm_go++;
    wait_idle("t3_idle");
    chk("t3_dm_rdata", 32'(dm_rdata), 32'h162B);
    chk("t3_if_rdata", 32'(if_rdata), 32'h1324);

    // rd and wr together: error flag, serviced as write, address change ignored
    lat = 3;
    sb.push_back(mk(1, 1, 16'h0300, 16'h1111, 16'h0000, 3));
    dm_n = 1; dm_rd_v = 1; dm_wr_v = 1; dm_a = 16'h0300; dm_d = 16'h1111;
    dm_go++;
    wait_serve("t4_serve_start");
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_mem_wr", 32'(mem_wr), 32'd1);
    chk("t4_mem_rd", 32'(mem_rd), 32'd0);
    chk("t4_dm_stall", 32'(dm_stall), 32'd1);
    glitch_go++;
    wait_idle("t4_idle");
    chk("t4_write_keeps_dm_rdata", 32'(dm_rdata), 32'h162B);
    chk("t4_err_clear", 32'(err), 32'd0);

    // asynchronous reset in SERVE_DM
    lat = 8;
    dm_n = 1; dm_rd_v = 0; dm_wr_v = 1; dm_a = 16'h0500; dm_d = 16'h2222;
    dm_go++;
    wait_serve("t5_serve_start");
    chk("t5_mem_addr_pre", 32'(mem_addr), 32'h0500);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("t5_rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("t5_rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("t5_rst_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    chk("t5_rst_done", 32'({if_done, dm_done}), 32'd0);
    @(negedge clk);
    @(negedge clk); #1 rst = 0;
    @(negedge clk); #4;
    chk("t5_idle_after_rst", 32'({mem_rd, mem_wr}), 32'd0);

    // mem_done while idle must not produce a completion
    idle_go++;
    @(negedge clk); #4;
    chk("t6_idle_if_done", 32'(if_done), 32'd0);
    chk("t6_idle_dm_done", 32'(dm_done), 32'd0);
    repeat (2) @(negedge clk); #4;
    chk("t6_idle_state", 32'({mem_rd, mem_wr}), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
